int_ack_sequencer: RTL and testbench
====================================

Name: int_ack_sequencer

Overview:
- CPU-side consumer of the PIC: watches the PIC's INT output and runs the two-pulse interrupt-acknowledge cycle (active-low INTA).
- Captures the vector byte the PIC drives on the data bus during the second pulse and hands it to the CPU core over a valid/ready handshake.
- Sits directly downstream of the PIC top: INT in, INTA out, data_Bus read.

Parameters:
- INTA_LOW_CYCLES, 2, clocks each INTA pulse is held low (>=1)
- INTA_GAP_CYCLES, 2, clocks INTA is high between pulse 1 and pulse 2 (>=1)
- SYNC_STAGES, 2, flip-flop stages on INT before the FSM (>=1)

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- INT  input  1  interrupt request from PIC, asynchronous to clk
- cpu_if  input  1  CPU interrupt-enable flag
- cpu_boundary  input  1  CPU at an instruction boundary, may accept an interrupt
- data_Bus  input  8  PIC data bus, sampled during pulse 2
- INTA  output  1  active-low acknowledge to PIC
- vec_out  output  8  captured interrupt vector
- vec_valid  output  1  vec_out holds a vector not yet consumed
- vec_ready  input  1  CPU accepts vector when vec_valid & vec_ready
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: INTA=1, vec_out=8'h00, vec_valid=0, busy=0, FSM=IDLE, counters=0, sync chain=0. Reset overrides every state, including mid-pulse: INTA is high at the first edge where reset=1.
- int_s is INT after SYNC_STAGES flops. It is the only use of INT.
- States are IDLE, P1, GAP, P2, HOLD.
- IDLE:
  - On an edge with int_s & cpu_if & cpu_boundary, go to P1 and load cnt=INTA_LOW_CYCLES-1.
  - Otherwise stay in IDLE.
- P1: INTA=0. cnt decrements each cycle. At cnt==0, go to GAP and load cnt=INTA_GAP_CYCLES-1.
- GAP: INTA=1. At cnt==0, go to P2 and load cnt=INTA_LOW_CYCLES-1.
- P2:
  - INTA=0.
  - At cnt==0, register data_Bus into vec_out on that same edge, set vec_valid=1 and go to HOLD.
  - data_Bus is sampled only in the last P2 cycle.
- HOLD:
  - INTA=1. vec_out is stable.
  - On vec_valid & vec_ready, clear vec_valid and return to IDLE.
  - vec_ready is ignored when vec_valid=0.
- INTA is registered (FSM-state decode through a flop) and glitch-free.
- Latency with defaults, starting state entry at edge k:
  - INTA low for cycles k and k+1, high for k+2 and k+3, low for k+4 and k+5.
  - Vector captured at edge k+6; vec_valid=1 from cycle k+6.
- Minimum re-trigger: one IDLE cycle after HOLD.
  - A still-high int_s restarts P1 on the edge after the IDLE cycle if the qualifiers are true.
- Once P1 is entered, the sequence always completes, even if INT, cpu_if or cpu_boundary drop.
  - No partial acknowledge is allowed; the PIC requires both pulses.
- If int_s drops in IDLE before qualification, nothing happens.
- If the qualifiers and int_s rise on the same edge that HOLD completes, stay in IDLE for that edge.
- cnt width is clog2(max(INTA_LOW_CYCLES, INTA_GAP_CYCLES)), minimum 1 bit. The counter never wraps; it is always reloaded before use.

Decomposition:
- Package int_ack_pkg holds:
  - the state enum (IDLE, P1, GAP, P2, HOLD)
  - INTA_ASSERT=1'b0 and INTA_DEASSERT=1'b1
  - VEC_RESET=8'h00
- One sub-module, bit_synchronizer (parameter STAGES; clk, reset, d, q), used for INT.

Test Plan:
- Reset during P1 (INTA=0) -> INTA=1 at the next edge, busy=0, vec_valid=0, and no vector is captured.
- INT=1, cpu_if=1, cpu_boundary=1, data_Bus=8'h4B during P2, vec_ready=1 -> INTA low/high/low pattern is 2/2/2 cycles; vec_out=8'h4B; vec_valid is high exactly 1 cycle; busy falls after the handshake.
- INT=1, cpu_if=0 for 20 cycles, then cpu_if=1 -> INTA stays 1 while cpu_if=0; the sequence starts after cpu_if rises; no early pulse.
- INT dropped during GAP, data_Bus=8'h27 -> pulse 2 still occurs and vec_out=8'h27.
- vec_ready held 0 for 10 cycles after capture, data_Bus changes to 8'hFF -> vec_out stays at the captured value, vec_valid stays 1, INTA stays 1, no new sequence; on vec_ready=1 the FSM returns to IDLE.
- Parameters INTA_LOW_CYCLES=1, INTA_GAP_CYCLES=3, INT held high -> pulses 1 low / 3 high / 1 low; back-to-back sequences are separated by exactly one IDLE cycle after each handshake.

Source files
------------

// File: rtl/int_ack_pkg.sv
// Shared types and constants for the interrupt-acknowledge sequencer.
// Holds the FSM state encoding, the INTA polarity constants and the counter width helper.
package int_ack_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    GAP  = 3'd2,
    P2   = 3'd3,
    HOLD = 3'd4
  } ack_state_e;

  localparam logic       INTA_ASSERT   = 1'b0;
  localparam logic       INTA_DEASSERT = 1'b1;
  localparam logic [7:0] VEC_RESET     = 8'h00;

  // Counter holds values up to max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m <= 1) begin
      return 1;
    end else begin
      return $clog2(m);
    end
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // shift chain, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/int_ack_sequencer.sv
// Runs the two-pulse INTA cycle toward the PIC and hands the captured
// vector byte to the CPU core through a valid/ready handshake.
module int_ack_sequencer
  import int_ack_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       cpu_if,
  input  logic       cpu_boundary,
  input  logic [7:0] data_Bus,
  output logic       INTA,
  output logic [7:0] vec_out,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       busy
);

  localparam int CNT_W = cnt_width(INTA_LOW_CYCLES, INTA_GAP_CYCLES);
  localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             int_s;
  ack_state_e       state_r;
  ack_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             capture_s;
  logic             release_s;
  logic             inta_r;
  logic [7:0]       vec_out_r;
  logic             vec_valid_r;
  logic             busy_r;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (INT),
    .q     (int_s)
  );

  // next-state and counter logic; once P1 is entered the sequence always completes
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (int_s && cpu_if && cpu_boundary) begin
          state_nxt_s = P1;
          cnt_nxt_s   = LOW_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      P1: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = GAP_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = P2;
          cnt_nxt_s   = LOW_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      P2: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = HOLD;
          capture_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (vec_valid_r && vec_ready) begin
          state_nxt_s = IDLE;
          release_s   = 1'b1;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // state register plus outputs decoded from the next state so INTA is a clean flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      inta_r      <= INTA_DEASSERT;
      vec_out_r   <= VEC_RESET;
      vec_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      inta_r  <= ((state_nxt_s == P1) || (state_nxt_s == P2)) ? INTA_ASSERT : INTA_DEASSERT;
      busy_r  <= (state_nxt_s != IDLE);
      if (capture_s) begin
        vec_out_r   <= data_Bus;
        vec_valid_r <= 1'b1;
      end else if (release_s) begin
        vec_valid_r <= 1'b0;
      end
    end
  end

  assign INTA      = inta_r;
  assign vec_out   = vec_out_r;
  assign vec_valid = vec_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Directed, table-driven bench for int_ack_sequencer (default and 1/3/1 timing instances).
module tb_int_ack_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       int_in, cpu_if, cpu_boundary, vec_ready;
  logic [7:0] data_bus;
  logic       inta, vec_valid, busy;
  logic [7:0] vec_out;

  logic       int_in2, cpu_if2, cpu_boundary2, vec_ready2;
  logic [7:0] data_bus2;
  logic       inta2, vec_valid2, busy2;
  logic [7:0] vec_out2;

  int n_checks = 0;
  int n_fail   = 0;

  int_ack_sequencer dut (
    .clk(clk), .reset(reset), .INT(int_in), .cpu_if(cpu_if), .cpu_boundary(cpu_boundary),
    .data_Bus(data_bus), .INTA(inta), .vec_out(vec_out), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .busy(busy)
  );

  int_ack_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(3), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .INT(int_in2), .cpu_if(cpu_if2), .cpu_boundary(cpu_boundary2),
    .data_Bus(data_bus2), .INTA(inta2), .vec_out(vec_out2), .vec_valid(vec_valid2),
    .vec_ready(vec_ready2), .busy(busy2)
  );

  typedef struct {
    logic       int_v;
    logic       cif;
    logic       cb;
    logic [7:0] data;
    logic       rdy;
    logic       e_inta;
    logic       e_valid;
    logic       e_busy;
    logic [7:0] e_vec;
  } row_t;

  row_t tbl[11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic e_inta, input logic e_valid,
                            input logic e_busy);
    check({tag, " inta"}, {7'd0, inta}, {7'd0, e_inta});
    check({tag, " valid"}, {7'd0, vec_valid}, {7'd0, e_valid});
    check({tag, " busy"}, {7'd0, busy}, {7'd0, e_busy});
  endtask

  // expected 1/3/1 pattern for dut2 from the first P1 edge, two full sequences
  logic e2_inta[14]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1};
  logic e2_busy[14]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
  logic e2_valid[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};

  initial begin
    // row: INT cpu_if boundary data ready | INTA valid busy vec (after the edge)
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b1, 1'b1, 8'h4B};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4B};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4B};

    reset = 1'b1;
    int_in = 1'b0; cpu_if = 1'b0; cpu_boundary = 1'b0; vec_ready = 1'b0; data_bus = 8'h00;
    int_in2 = 1'b0; cpu_if2 = 1'b0; cpu_boundary2 = 1'b0; vec_ready2 = 1'b0; data_bus2 = 8'h00;
    step();
    step();
    check_main("reset", 1'b1, 1'b0, 1'b0);
    check("reset vec", vec_out, 8'h00);
    reset = 1'b0;

    // basic sequence, 2/2/2 pulse timing and one-cycle valid
    for (int i = 0; i < 11; i++) begin
      int_in = tbl[i].int_v; cpu_if = tbl[i].cif; cpu_boundary = tbl[i].cb;
      data_bus = tbl[i].data; vec_ready = tbl[i].rdy;
      step();
      check_main($sformatf("row%0d", i), tbl[i].e_inta, tbl[i].e_valid, tbl[i].e_busy);
      check($sformatf("row%0d vec", i), vec_out, tbl[i].e_vec);
    end

    // reset in the middle of pulse 1
    int_in = 1'b1; cpu_if = 1'b1; cpu_boundary = 1'b1; vec_ready = 1'b1; data_bus = 8'hC3;
    repeat (3) step();
    check("rstP1 pre inta", {7'd0, inta}, 8'h00);
    reset = 1'b1;
    step();
    check_main("rstP1", 1'b1, 1'b0, 1'b0);
    check("rstP1 vec", vec_out, 8'h00);
    reset = 1'b0; int_in = 1'b0;
    repeat (4) step();
    check_main("rstP1 after", 1'b1, 1'b0, 1'b0);
    check("rstP1 after vec", vec_out, 8'h00);

    // interrupts disabled for 20 cycles, then enabled
    int_in = 1'b1; cpu_if = 1'b0; cpu_boundary = 1'b1; data_bus = 8'h3C; vec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("if0 c%0d inta", i), {7'd0, inta}, 8'h01);
      check($sformatf("if0 c%0d busy", i), {7'd0, busy}, 8'h00);
    end
    cpu_if = 1'b1;
    step();
    check("if1 p1a", {7'd0, inta}, 8'h00);
    int_in = 1'b0; cpu_if = 1'b0;
    step(); check("if1 p1b", {7'd0, inta}, 8'h00);
    step(); check("if1 gapa", {7'd0, inta}, 8'h01);
    step(); check("if1 gapb", {7'd0, inta}, 8'h01);
    step(); check("if1 p2a", {7'd0, inta}, 8'h00);
    step(); check("if1 p2b", {7'd0, inta}, 8'h00);
    step();
    check_main("if1 hold", 1'b1, 1'b1, 1'b1);
    check("if1 vec", vec_out, 8'h3C);
    step();
    check_main("if1 done", 1'b1, 1'b0, 1'b0);

    // INT and qualifiers drop during GAP, then a stalled handshake
    int_in = 1'b1; cpu_if = 1'b1; cpu_boundary = 1'b1; data_bus = 8'h27; vec_ready = 1'b0;
    repeat (3) step();
    check("drop p1", {7'd0, inta}, 8'h00);
    step();
    step();
    check("drop gap", {7'd0, inta}, 8'h01);
    int_in = 1'b0; cpu_if = 1'b0; cpu_boundary = 1'b0;
    step(); check("drop gapb", {7'd0, inta}, 8'h01);
    step(); check("drop p2a", {7'd0, inta}, 8'h00);
    step(); check("drop p2b", {7'd0, inta}, 8'h00);
    step();
    check_main("drop hold", 1'b1, 1'b1, 1'b1);
    check("drop vec", vec_out, 8'h27);
    data_bus = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        int_in = 1'b1; cpu_if = 1'b1; cpu_boundary = 1'b1;
      end else begin
        int_in = 1'b0;
      end
      step();
      check_main($sformatf("stall c%0d", i), 1'b1, 1'b1, 1'b1);
      check($sformatf("stall c%0d vec", i), vec_out, 8'h27);
    end
    vec_ready = 1'b1;
    step();
    check_main("stall release", 1'b1, 1'b0, 1'b0);
    check("stall release vec", vec_out, 8'h27);
    step();
    check_main("stall idle", 1'b1, 1'b0, 1'b0);

    // 1/3/1 instance with INT held high: back-to-back sequences
    int_in2 = 1'b1; cpu_if2 = 1'b1; cpu_boundary2 = 1'b1; vec_ready2 = 1'b1; data_bus2 = 8'h5A;
    step();
    step();
    check("p2 pre inta", {7'd0, inta2}, 8'h01);
    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("p2 c%0d inta", i), {7'd0, inta2}, {7'd0, e2_inta[i]});
      check($sformatf("p2 c%0d busy", i), {7'd0, busy2}, {7'd0, e2_busy[i]});
      check($sformatf("p2 c%0d valid", i), {7'd0, vec_valid2}, {7'd0, e2_valid[i]});
      if (e2_valid[i]) begin
        check($sformatf("p2 c%0d vec", i), vec_out2, 8'h5A);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
